// File: rtl/match_pkg.sv
// -----------------------------------------------------------------------------
// match_pkg -- shared types and constants for the innings controller.
//   state_t        : innings FSM encoding (also driven out on innings_ctrl.state)
//   EV_*           : delivery kind codes carried on ev_kind
//   RES_*          : match result codes carried on result
//   BALLS_PER_OVER : legal deliveries that make one over
//   clamp_runs()   : maps the out-of-range runs code 7 onto 6
// -----------------------------------------------------------------------------
package match_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INN1  = 3'd1,
      ST_BREAK = 3'd2,
      ST_INN2  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] EV_LEGAL  = 2'b00;
   localparam logic [1:0] EV_WIDE   = 2'b01;
   localparam logic [1:0] EV_NOBALL = 2'b10;
   localparam logic [1:0] EV_WICKET = 2'b11;

   localparam logic [1:0] RES_NONE  = 2'b00;
   localparam logic [1:0] RES_TEAM1 = 2'b01;
   localparam logic [1:0] RES_TEAM2 = 2'b10;
   localparam logic [1:0] RES_TIE   = 2'b11;

   localparam int BALLS_PER_OVER = 6;

   function automatic logic [2:0] clamp_runs(input logic [2:0] r);
      return (r == 3'd7) ? 3'd6 : r;
   endfunction

endpackage

// File: rtl/ball_over_counter.sv
// -----------------------------------------------------------------------------
// ball_over_counter -- legal-ball and completed-over counting.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear of ball/overs (start of a new innings)
//   legal_inc  : one accepted legal delivery this cycle
//   ball       : legal balls in the current over (0..5), registered
//   overs      : completed overs, registered
//   over_end   : one-cycle pulse, registered, following the edge that closes an over
//   over_wrap  : combinational, this cycle's legal ball closes the over; lets the
//                parent end the innings on the same edge
// -----------------------------------------------------------------------------
module ball_over_counter
   import match_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       legal_inc,
   output logic [2:0] ball,
   output logic [3:0] overs,
   output logic       over_end,
   output logic       over_wrap
);

   localparam logic [2:0] LAST_BALL = 3'(BALLS_PER_OVER - 1);

   assign over_wrap = legal_inc && (ball == LAST_BALL);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ball     <= 3'd0;
         overs    <= 4'd0;
         over_end <= 1'b0;
      end else begin
         over_end <= over_wrap;
         if (legal_inc) begin
            if (over_wrap) begin
               ball  <= 3'd0;
               overs <= overs + 4'd1;
            end else begin
               ball  <= ball + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/innings_ctrl.sv
// -----------------------------------------------------------------------------
// innings_ctrl -- two-innings limited-overs match scorer.
// Optional feature macro: MATCH_FREE_HIT_EN (a no-ball arms a free hit; a wicket
// on the free-hit delivery scores as a legal ball but does not add a wicket).
// Parameters: MAX_OVERS (1..9), MAX_WKTS (1..10).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : IDLE -> INN1, BREAK -> INN2; ignored elsewhere
//   ev_valid/ev_kind/ev_runs, ev_ready : delivery event handshake
//   score, wicket, overs, ball         : current innings counters
//   innings, target, state, result     : match progress
//   over_end                           : one-cycle over-complete pulse
// Handshake: an event is consumed on a rising edge where ev_valid && ev_ready.
// ev_ready is registered and high exactly in INN1/INN2; it drops on the same
// edge that ends the innings, so no event is taken after the closing one.
// All outputs are registered; an accepted event shows on the next edge.
// -----------------------------------------------------------------------------
module innings_ctrl
   import match_pkg::*;
#(
   parameter int MAX_OVERS = 2,
   parameter int MAX_WKTS  = 10
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       ev_valid,
   input  logic [1:0] ev_kind,
   input  logic [2:0] ev_runs,
   output logic       ev_ready,
   output logic [8:0] score,
   output logic [3:0] wicket,
   output logic [3:0] overs,
   output logic [2:0] ball,
   output logic       innings,
   output logic [8:0] target,
   output logic [2:0] state,
   output logic [1:0] result,
   output logic       over_end
);

   localparam logic [3:0] OVERS_LIM = 4'(MAX_OVERS);
   localparam logic [3:0] WKTS_LIM  = 4'(MAX_WKTS);

   state_t     st;
   logic       accept;
   logic       in_play;
   logic [2:0] runs_eff;
   logic [3:0] add;
   logic       legal_inc;
   logic       wkt_inc;
   logic [9:0] sum;
   logic [8:0] score_next;
   logic [3:0] wkt_next;
   logic [3:0] overs_next;
   logic       over_wrap;
   logic       inn_end;
   logic       chase_won;
   logic       cnt_clr;
   logic [8:0] target_calc;
   logic [1:0] result_calc;

`ifdef MATCH_FREE_HIT_EN
   logic free_hit;
`endif

   assign state    = st;
   assign in_play  = (st == ST_INN1) || (st == ST_INN2);
   assign accept   = ev_valid && in_play;
   assign runs_eff = clamp_runs(ev_runs);
   assign cnt_clr  = (st == ST_BREAK) && start;

   ball_over_counter u_bo (
      .clk       (clk),
      .rst       (rst),
      .clr       (cnt_clr),
      .legal_inc (legal_inc),
      .ball      (ball),
      .overs     (overs),
      .over_end  (over_end),
      .over_wrap (over_wrap)
   );

   always_comb begin
      add       = 4'd0;
      legal_inc = 1'b0;
      wkt_inc   = 1'b0;
      if (accept) begin
         case (ev_kind)
            EV_LEGAL: begin
               add       = {1'b0, runs_eff};
               legal_inc = 1'b1;
            end
            EV_WIDE, EV_NOBALL: begin
               add = 4'd1 + {1'b0, runs_eff};
            end
            default: begin // EV_WICKET
               add       = {1'b0, runs_eff};
               legal_inc = 1'b1;
`ifdef MATCH_FREE_HIT_EN
               wkt_inc   = !free_hit;
`else
               wkt_inc   = 1'b1;
`endif
            end
         endcase
      end

      sum        = {1'b0, score} + {6'd0, add};
      score_next = sum[9] ? 9'd511 : sum[8:0];
      wkt_next   = wicket + {3'd0, wkt_inc};
      overs_next = overs + {3'd0, over_wrap};

      inn_end    = accept && ((wkt_next == WKTS_LIM) || (overs_next == OVERS_LIM));
      chase_won  = accept && (st == ST_INN2) && (score_next >= target);

      target_calc = (score_next == 9'd511) ? 9'd511 : score_next + 9'd1;

      // target is at least 1 whenever INN2 is active, so target - 1 cannot wrap
      if (score_next >= target)
         result_calc = RES_TEAM2;
      else if (score_next == target - 9'd1)
         result_calc = RES_TIE;
      else
         result_calc = RES_TEAM1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= ST_IDLE;
         score    <= 9'd0;
         wicket   <= 4'd0;
         innings  <= 1'b0;
         target   <= 9'd0;
         result   <= RES_NONE;
         ev_ready <= 1'b0;
`ifdef MATCH_FREE_HIT_EN
         free_hit <= 1'b0;
`endif
      end else begin
         case (st)
            ST_IDLE: begin
               if (start) begin
                  st       <= ST_INN1;
                  ev_ready <= 1'b1;
               end
            end
            ST_INN1, ST_INN2: begin
               if (accept) begin
                  score  <= score_next;
                  wicket <= wkt_next;
`ifdef MATCH_FREE_HIT_EN
                  if (ev_kind == EV_NOBALL)
                     free_hit <= 1'b1;
                  else if (ev_kind != EV_WIDE)
                     free_hit <= 1'b0;
`endif
                  if (st == ST_INN1 && inn_end) begin
                     st       <= ST_BREAK;
                     ev_ready <= 1'b0;
                     target   <= target_calc;
                  end else if (st == ST_INN2 && (inn_end || chase_won)) begin
                     st       <= ST_DONE;
                     ev_ready <= 1'b0;
                     result   <= result_calc;
                  end
               end
            end
            ST_BREAK: begin
               if (start) begin
                  st       <= ST_INN2;
                  innings  <= 1'b1;
                  score    <= 9'd0;
                  wicket   <= 4'd0;
                  ev_ready <= 1'b1;
`ifdef MATCH_FREE_HIT_EN
                  free_hit <= 1'b0;
`endif
               end
            end
            default: ; // ST_DONE holds until reset
         endcase
      end
   end

endmodule

// File: tb/tb_innings_ctrl.sv
// -----------------------------------------------------------------------------
// tb_innings_ctrl -- table-driven bench for innings_ctrl (default parameters:
// 2 overs, 10 wickets). Honours MATCH_FREE_HIT_EN for the free-hit case.
// -----------------------------------------------------------------------------
module tb_innings_ctrl;
  import match_pkg::*;

  localparam int W = 37;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst, start, ev_valid;
  logic [1:0] ev_kind;
  logic [2:0] ev_runs;
  logic       ev_ready, innings, over_end;
  logic [8:0] score, target;
  logic [3:0] wicket, overs;
  logic [2:0] ball, state;
  logic [1:0] result;

  always #5 clk = ~clk;

  innings_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .ev_valid(ev_valid),
    .ev_kind(ev_kind), .ev_runs(ev_runs), .ev_ready(ev_ready),
    .score(score), .wicket(wicket), .overs(overs), .ball(ball),
    .innings(innings), .target(target), .state(state),
    .result(result), .over_end(over_end)
  );

  logic [W-1:0] act;
  assign act = {state, score, wicket, overs, ball, innings, target, result, over_end, ev_ready};

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic         r, s, v;
    logic [1:0]   k;
    logic [2:0]   rn;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           tests_run    = 0;
  int           tests_failed = 0;

  logic [2:0] e_st;
  logic [8:0] e_score, e_tgt;
  logic [3:0] e_wkt, e_ovr;
  logic [2:0] e_ball;
  logic       e_inn, e_oe, e_rdy;
  logic [1:0] e_res;

  function automatic logic [W-1:0] pack_exp();
    return {e_st, e_score, e_wkt, e_ovr, e_ball, e_inn, e_tgt, e_res, e_oe, e_rdy};
  endfunction

  function automatic string fmt(input logic [W-1:0] v);
    return $sformatf("st=%0d sc=%0d wk=%0d ov=%0d b=%0d inn=%0d tgt=%0d res=%0d oe=%0d rdy=%0d",
                     v[36:34], v[33:25], v[24:21], v[20:17], v[16:14], v[13],
                     v[12:4], v[3:2], v[1], v[0]);
  endfunction

  task automatic zero_exp();
    e_st = ST_IDLE; e_score = 0; e_tgt = 0; e_wkt = 0; e_ovr = 0;
    e_ball = 0; e_inn = 0; e_oe = 0; e_rdy = 0; e_res = RES_NONE;
  endtask

  task automatic add(input string nm, input logic r, input logic s, input logic v,
                     input logic [1:0] k, input logic [2:0] rn);
    vec_t t;
    t.name = nm; t.r = r; t.s = s; t.v = v; t.k = k; t.rn = rn;
    t.exp  = pack_exp();
    vecs.push_back(t);
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check_out(input string nm, input logic [W-1:0] want);
    tests_run++;
    if (act !== want) begin
      tests_failed++;
      $display("FAIL %s: got {%s} want {%s}", nm, fmt(act), fmt(want));
    end
  endtask

  // ---------------- bounded wait ----------------
  task automatic wait_state(input string nm, input logic [2:0] want_st, input int max_cycles);
    int n;
    n = 0;
    while (state !== want_st && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (state !== want_st) begin
      tests_failed++;
      $display("FAIL %s: wait for state %0d expired after %0d cycles (state=%0d)",
               nm, want_st, max_cycles, state);
    end
  endtask

  // reset, start, then 12 legal singles: innings 1 closes at 12, target 13
  task automatic inn1_twelve(input string p);
    zero_exp();
    add({p, "_rst"}, 1, 0, 0, EV_LEGAL, 0);
    e_st = ST_INN1; e_rdy = 1;
    add({p, "_start1"}, 0, 1, 0, EV_LEGAL, 0);
    for (int k = 1; k <= 12; k++) begin
      e_score = 9'(k); e_ball = 3'(k % 6); e_ovr = 4'(k / 6); e_oe = (k % 6 == 0);
      if (k == 12) begin e_st = ST_BREAK; e_tgt = 13; e_rdy = 0; end
      add($sformatf("%s_legal%0d", p, k), 0, 0, 1, EV_LEGAL, 1);
    end
    e_oe = 0;
  endtask

  task automatic start2(input string p);
    e_st = ST_INN2; e_inn = 1; e_score = 0; e_wkt = 0; e_ovr = 0; e_ball = 0;
    e_rdy = 1; e_oe = 0;
    add({p, "_start2"}, 0, 1, 0, EV_LEGAL, 0);
  endtask

  initial begin
    rst = 1; start = 0; ev_valid = 0; ev_kind = 0; ev_runs = 0;

    // reset-state check and bounded wait for IDLE
    @(posedge clk);
    #1;
    check_out("reset_state", '0);
    wait_state("reset_idle_wait", ST_IDLE, 4);

    // A: first innings by overs, then events ignored in BREAK
    zero_exp();
    add("a_rst_hold", 1, 0, 0, EV_LEGAL, 0);
    inn1_twelve("a");
    add("a_break_ignore", 0, 0, 1, EV_LEGAL, 4);

    // B: chase reaches target exactly; runs code 7 counts 6
    start2("b");
    e_score = 6;  e_ball = 1; add("b_six", 0, 0, 1, EV_LEGAL, 6);
    e_score = 12; e_ball = 2; add("b_runs7", 0, 0, 1, EV_LEGAL, 7);
    e_score = 13; e_ball = 3; e_st = ST_DONE; e_res = RES_TEAM2; e_rdy = 0;
    add("b_chase_won", 0, 0, 1, EV_LEGAL, 1);
    add("b_done_ignore", 0, 1, 1, EV_LEGAL, 4);

    // C: wide does not advance ball, over_end pulse width, extras, free hit
    zero_exp();
    add("c_rst", 1, 0, 0, EV_LEGAL, 0);
    e_st = ST_INN1; e_rdy = 1;
    add("c_start", 0, 1, 0, EV_LEGAL, 0);
    for (int k = 1; k <= 5; k++) begin
      e_ball = 3'(k);
      add($sformatf("c_dot%0d", k), 0, 0, 1, EV_LEGAL, 0);
    end
    e_score = 1; add("c_wide", 0, 0, 1, EV_WIDE, 0);
    e_ball = 0; e_ovr = 1; e_oe = 1; add("c_over_close", 0, 0, 1, EV_LEGAL, 0);
    e_oe = 0; add("c_oe_drop", 0, 0, 0, EV_LEGAL, 0);
    add("c_start_ignored", 0, 1, 0, EV_LEGAL, 0);
    e_score = 8; add("c_noball7", 0, 0, 1, EV_NOBALL, 7);
    e_score = 10; e_ball = 1;
`ifdef MATCH_FREE_HIT_EN
    e_wkt = 0;
`else
    e_wkt = 1;
`endif
    add("c_wkt_after_nb", 0, 0, 1, EV_WICKET, 2);
    e_ball = 2; e_wkt = e_wkt + 1;
    add("c_wkt_plain", 0, 0, 1, EV_WICKET, 0);
    e_score = 14; add("c_wide3", 0, 0, 1, EV_WIDE, 3);

    // D: all out on the tenth wicket
    zero_exp();
    add("d_rst", 1, 0, 0, EV_LEGAL, 0);
    e_st = ST_INN1; e_rdy = 1;
    add("d_start", 0, 1, 0, EV_LEGAL, 0);
    for (int k = 1; k <= 10; k++) begin
      e_wkt = 4'(k); e_ball = 3'(k % 6); e_ovr = 4'(k / 6); e_oe = (k == 6);
      if (k == 10) begin e_st = ST_BREAK; e_tgt = 1; e_rdy = 0; end
      add($sformatf("d_wkt%0d", k), 0, 0, 1, EV_WICKET, 0);
    end
    add("d_break_ignore", 0, 0, 1, EV_WICKET, 3);

    // E: overs exhausted one short of target -> tie
    inn1_twelve("e");
    start2("e");
    for (int k = 1; k <= 12; k++) begin
      e_score = 9'(k); e_ball = 3'(k % 6); e_ovr = 4'(k / 6); e_oe = (k % 6 == 0);
      if (k == 12) begin e_st = ST_DONE; e_res = RES_TIE; e_rdy = 0; end
      add($sformatf("e_legal%0d", k), 0, 0, 1, EV_LEGAL, 1);
    end

    // F: overs exhausted well short -> team 1
    inn1_twelve("f");
    start2("f");
    for (int k = 1; k <= 12; k++) begin
      e_score = (k <= 10) ? 9'(k) : 9'd10;
      e_ball = 3'(k % 6); e_ovr = 4'(k / 6); e_oe = (k % 6 == 0);
      if (k == 12) begin e_st = ST_DONE; e_res = RES_TEAM1; e_rdy = 0; end
      add($sformatf("f_legal%0d", k), 0, 0, 1, EV_LEGAL, (k <= 10) ? 3'd1 : 3'd0);
    end

    // G: reset in the middle of innings 2
    inn1_twelve("g");
    start2("g");
    for (int k = 1; k <= 3; k++) begin
      e_score = 9'(2 * k); e_ball = 3'(k);
      add($sformatf("g_two%0d", k), 0, 0, 1, EV_LEGAL, 2);
    end
    zero_exp();
    add("g_mid_rst", 1, 1, 1, EV_LEGAL, 4);
    add("g_idle_after_rst", 0, 0, 1, EV_LEGAL, 4);

    // ---------------- apply + scoreboard ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      rst      = vecs[i].r;
      start    = vecs[i].s;
      ev_valid = vecs[i].v;
      ev_kind  = vecs[i].k;
      ev_runs  = vecs[i].rn;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check_out(vecs[i].name, exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
